// File: rtl/ball_motion.sv
// ball_motion: ball position engine for a two-player field.
// WAIT holds the ball centred until start. SERVE pauses for SERVE_TICKS frame
// ticks and then pulses serve. MOVE steps the centre along the 16-way heading
// on every tick, clamped to the field, until a goal edge recentres the ball.
// Optional feature macro: SCORE_EN adds saturating per-player scores
// (score_p1, score_p2). When the scoring player reaches 9 the ball returns to
// WAIT instead of SERVE.
// state_dbg exposes the FSM state: 0 WAIT, 1 SERVE, 2 MOVE.
// There is no valid/ready handshake here. tick is a one-cycle strobe. start,
// goal_p1 and goal_p2 are levels, and goals act only on their rising edge.
module ball_motion #(
    parameter logic [12:0] H_MAX       = 13'd2560,
    parameter logic [12:0] V_MAX       = 13'd1920,
    parameter logic [7:0]  SERVE_TICKS = 8'd60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic [3:0]  direction,
    input  logic [12:0] move_speed,
    input  logic [12:0] size,
    input  logic        goal_p1,
    input  logic        goal_p2,
    output logic [12:0] x,
    output logic [12:0] y,
    output logic        serve,
    output logic        moving,
`ifdef SCORE_EN
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
`endif
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_SERVE = 2'd1,
        ST_MOVE  = 2'd2
    } state_t;

    localparam logic [12:0] X_CENTRE = H_MAX >> 1;
    localparam logic [12:0] Y_CENTRE = V_MAX >> 1;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [12:0] x_q, x_d, y_q, y_d;
    logic        serve_q, serve_d;
    logic        moving_q;
    logic        gp1_q, gp2_q;
    logic        rst_meta_q, run_q;
`ifdef SCORE_EN
    logic [3:0]  score_p1_q, score_p1_d, score_p2_q, score_p2_d;
`endif

    // Heading decode
    logic [1:0]  quad;
    logic [1:0]  off;
    logic [4:0]  kx_mag, ky_mag;
    logic        x_neg, y_down;

    // Step arithmetic
    logic [17:0]        prod_x, prod_y;
    logic signed [13:0] dx_s, dy_s, x_cur, y_cur, nx, ny;
    logic [12:0]        x_hi, y_hi, x_clamp, y_clamp;

    // Goal edges and serve counter increment
    logic       rise_p1, rise_p2, goal_hit;
    logic [8:0] cnt_inc;

    // Magnitude of a trig component (scaled by 16) by its angular offset
    // from the axis, in 22.5-degree steps.
    function automatic logic [4:0] k_mag(input logic [2:0] steps);
        logic [4:0] k;
        case (steps)
            3'd0:    k = 5'd16;
            3'd1:    k = 5'd15;
            3'd2:    k = 5'd11;
            3'd3:    k = 5'd6;
            default: k = 5'd0;
        endcase
        return k;
    endfunction

    // Release reset through two flops so the FSM starts on a clean edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            run_q      <= rst_meta_q;
        end
    end

    // Split the heading into quadrant and offset, then select component
    // magnitudes and signs. Headings run clockwise from up. Screen y grows
    // downward.
    always_comb begin
        quad = direction[3:2];
        off  = direction[1:0];
        if (!quad[0]) begin
            kx_mag = k_mag(3'd4 - {1'b0, off});
            ky_mag = k_mag({1'b0, off});
        end else begin
            kx_mag = k_mag({1'b0, off});
            ky_mag = k_mag(3'd4 - {1'b0, off});
        end
        x_neg  = quad[1];
        y_down = quad[1] ^ quad[0];
    end

    // Per-tick step and clamped candidate position. Clamping lands exactly
    // on the limit so a downstream equality wall test sees the contact.
    always_comb begin
        prod_x  = {5'd0, move_speed} * {13'd0, kx_mag};
        prod_y  = {5'd0, move_speed} * {13'd0, ky_mag};
        dx_s    = $signed(14'(prod_x >> 4));
        dy_s    = $signed(14'(prod_y >> 4));
        x_cur   = $signed({1'b0, x_q});
        y_cur   = $signed({1'b0, y_q});
        nx      = x_neg  ? (x_cur - dx_s) : (x_cur + dx_s);
        ny      = y_down ? (y_cur + dy_s) : (y_cur - dy_s);
        x_hi    = H_MAX - size;
        y_hi    = V_MAX - size;
        if (nx < $signed({1'b0, size})) begin
            x_clamp = size;
        end else if (nx > $signed({1'b0, x_hi})) begin
            x_clamp = x_hi;
        end else begin
            x_clamp = nx[12:0];
        end
        if (ny < $signed({1'b0, size})) begin
            y_clamp = size;
        end else if (ny > $signed({1'b0, y_hi})) begin
            y_clamp = y_hi;
        end else begin
            y_clamp = ny[12:0];
        end
    end

    // Goal rising edges. Player 1 wins a simultaneous edge.
    always_comb begin
        rise_p1  = goal_p1 & ~gp1_q;
        rise_p2  = goal_p2 & ~gp2_q;
        goal_hit = rise_p1 | rise_p2;
        cnt_inc  = {1'b0, cnt_q} + {8'd0, tick};
    end

    // Next state, serve counter, position and scores.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        serve_d = 1'b0;
`ifdef SCORE_EN
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
`endif
        case (state_q)
            ST_WAIT: begin
                x_d = X_CENTRE;
                y_d = Y_CENTRE;
                if (start) begin
                    state_d = ST_SERVE;
                    cnt_d   = 8'd0;
                end
            end
            ST_SERVE: begin
                x_d = X_CENTRE;
                y_d = Y_CENTRE;
                if (cnt_inc >= {1'b0, SERVE_TICKS}) begin
                    state_d = ST_MOVE;
                    serve_d = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            ST_MOVE: begin
                if (goal_hit) begin
                    // A goal outranks a coincident tick: the step is dropped.
                    state_d = ST_SERVE;
                    cnt_d   = 8'd0;
                    x_d     = X_CENTRE;
                    y_d     = Y_CENTRE;
`ifdef SCORE_EN
                    if (rise_p1) begin
                        if (score_p2_q != 4'd9) begin
                            score_p2_d = score_p2_q + 4'd1;
                        end
                        if (score_p2_d == 4'd9) begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        if (score_p1_q != 4'd9) begin
                            score_p1_d = score_p1_q + 4'd1;
                        end
                        if (score_p1_d == 4'd9) begin
                            state_d = ST_WAIT;
                        end
                    end
`endif
                end else if (tick) begin
                    x_d = x_clamp;
                    y_d = y_clamp;
                end
            end
            default: begin
                state_d = ST_WAIT;
                x_d     = X_CENTRE;
                y_d     = Y_CENTRE;
            end
        endcase
    end

    // State and output registers. Nothing advances until reset release has
    // passed through the synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_WAIT;
            cnt_q    <= 8'd0;
            x_q      <= X_CENTRE;
            y_q      <= Y_CENTRE;
            serve_q  <= 1'b0;
            moving_q <= 1'b0;
            gp1_q    <= 1'b0;
            gp2_q    <= 1'b0;
`ifdef SCORE_EN
            score_p1_q <= 4'd0;
            score_p2_q <= 4'd0;
`endif
        end else if (run_q) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            serve_q  <= serve_d;
            moving_q <= (state_d == ST_MOVE);
            gp1_q    <= goal_p1;
            gp2_q    <= goal_p2;
`ifdef SCORE_EN
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
`endif
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign serve     = serve_q;
    assign moving    = moving_q;
    assign state_dbg = state_q;
`ifdef SCORE_EN
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
`endif

endmodule

// File: tb/tb_ball_motion.sv
// Testbench for ball_motion. Directed steps cover reset, serve delay, the
// diagonal step, the wall clamp, goal edge priority and reset during MOVE.
// These are followed by randomized play checked against a trig-based
// reference model. SCORE_EN adds score checks and a saturation sequence.
module tb_ball_motion;
  localparam int HMAX = 2560;
  localparam int VMAX = 1920;
  localparam int HC = 1280;
  localparam int VC = 960;
  localparam int STICKS = 3;
  localparam int M_WAIT = 0;
  localparam int M_SERVE = 1;
  localparam int M_MOVE = 2;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic goal_p1 = 1'b0;
  logic goal_p2 = 1'b0;
  logic [3:0] direction = 4'd0;
  logic [12:0] move_speed = 13'd0;
  logic [12:0] size = 13'd8;
  logic [12:0] x, y;
  logic serve, moving;
  logic [1:0] state_dbg;
`ifdef SCORE_EN
  logic [3:0] score_p1, score_p2;
`endif

  int n_tests = 0;
  int n_fail = 0;

  // reference model state
  int m_mode, m_cnt, m_x, m_y, m_serve, m_s1, m_s2;
  bit m_g1, m_g2;
  logic [12:0] exp_q[$];

  ball_motion #(
    .H_MAX(13'd2560),
    .V_MAX(13'd1920),
    .SERVE_TICKS(8'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .start(start),
    .direction(direction),
    .move_speed(move_speed),
    .size(size),
    .goal_p1(goal_p1),
    .goal_p2(goal_p2),
    .x(x),
    .y(y),
    .serve(serve),
    .moving(moving),
`ifdef SCORE_EN
    .score_p1(score_p1),
    .score_p2(score_p2),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // signed step component: magnitude truncated, sign from the heading
  function automatic int comp(int spd, int k);
    if (k < 0) return -((spd * (-k)) / 16);
    return (spd * k) / 16;
  endfunction

  task automatic m_reset();
    m_mode = M_WAIT;
    m_cnt = 0;
    m_x = HC;
    m_y = VC;
    m_serve = 0;
    m_s1 = 0;
    m_s2 = 0;
    m_g1 = 1'b0;
    m_g2 = 1'b0;
  endtask

  // advance the model by one clock edge using the inputs now applied
  task automatic model_edge();
    bit r1, r2;
    int kx, ky, spd, sz;
    real a;
    r1 = goal_p1 && !m_g1;
    r2 = goal_p2 && !m_g2;
    m_serve = 0;
    if (!rst) begin
      m_reset();
      return;
    end
    case (m_mode)
      M_WAIT: begin
        if (start) begin
          m_mode = M_SERVE;
          m_cnt = 0;
        end
      end
      M_SERVE: begin
        if (tick) m_cnt++;
        if (m_cnt >= STICKS) begin
          m_mode = M_MOVE;
          m_serve = 1;
        end
      end
      default: begin
        if (r1 || r2) begin
          m_mode = M_SERVE;
          m_cnt = 0;
          m_x = HC;
          m_y = VC;
`ifdef SCORE_EN
          if (r1) begin
            if (m_s2 < 9) m_s2++;
            if (m_s2 == 9) m_mode = M_WAIT;
          end else begin
            if (m_s1 < 9) m_s1++;
            if (m_s1 == 9) m_mode = M_WAIT;
          end
`endif
        end else if (tick) begin
          spd = int'(move_speed);
          sz = int'(size);
          a = real'(direction) * 22.5 * PI / 180.0;
          kx = int'(16.0 * $sin(a));
          ky = int'(16.0 * $cos(a));
          m_x = clampi(m_x + comp(spd, kx), sz, HMAX - sz);
          m_y = clampi(m_y - comp(spd, ky), sz, VMAX - sz);
        end
      end
    endcase
    m_g1 = goal_p1;
    m_g2 = goal_p2;
  endtask

  // scoreboard: compare every observable output with the model
  task automatic check_all();
    logic [12:0] ex;
    ex = exp_q.pop_front();
    chk("x", x, ex);
    chk("y", y, m_y);
    chk("serve", serve, m_serve);
    chk("moving", moving, (m_mode == M_MOVE));
    chk("state", state_dbg, m_mode);
`ifdef SCORE_EN
    chk("score_p1", score_p1, m_s1);
    chk("score_p2", score_p2, m_s2);
`endif
  endtask

  // driver: inputs are already applied; take one edge and check #1 after it
  task automatic step();
    model_edge();
    exp_q.push_back(13'(m_x));
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) step();
    tick = 1'b0;
  endtask

  initial begin
    m_reset();
    // reset state
    step();
    step();
    chk("rst_x", x, HC);
    chk("rst_y", y, VC);
    chk("rst_serve", serve, 0);
    chk("rst_moving", moving, 0);
    chk("rst_state", state_dbg, M_WAIT);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // serve delay
    direction = 4'd2;
    move_speed = 13'd16;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("serve_entry", state_dbg, M_SERVE);
    ticks(2);
    step();
    chk("serve_early", serve, 0);
    chk("serve_early_state", state_dbg, M_SERVE);
    ticks(1);
    chk("serve_pulse", serve, 1);
    chk("serve_moving", moving, 1);
    step();
    chk("serve_one_cycle", serve, 0);
    chk("moving_hold", moving, 1);

    // diagonal step
    ticks(1);
    chk("diag_x", x, 1291);
    chk("diag_y", y, 949);

    // goal edge with coincident tick, then a held level
    goal_p1 = 1'b1;
    ticks(1);
    chk("goal_x", x, HC);
    chk("goal_y", y, VC);
    chk("goal_state", state_dbg, M_SERVE);
`ifdef SCORE_EN
    chk("goal_score_p2", score_p2, 1);
`endif
    ticks(20);
    chk("goal_held_state", state_dbg, M_MOVE);
    chk("goal_held_x", x, HC + 17 * 11);
    goal_p1 = 1'b0;
    step();

    // recentre via player-2 goal, back to MOVE
    goal_p2 = 1'b1;
    step();
    goal_p2 = 1'b0;
    chk("goal2_state", state_dbg, M_SERVE);
    ticks(3);
    chk("goal2_move", state_dbg, M_MOVE);

    // wall clamp
    direction = 4'd8;
    move_speed = 13'd945;
    ticks(1);
    chk("wall_pre_y", y, 1905);
    direction = 4'd7;
    move_speed = 13'd16;
    ticks(1);
    chk("wall_y", y, 1912);
    chk("wall_x", x, 1286);
    ticks(1);
    chk("wall_hold_y", y, 1912);

    // reset in MOVE
    goal_p1 = 1'b1;
    step();
    goal_p1 = 1'b0;
    ticks(3);
    direction = 4'd12;
    move_speed = 13'd245;
    ticks(4);
    chk("pre_rst_x", x, 300);
    chk("pre_rst_y", y, VC);
    rst = 1'b0;
    step();
    chk("mid_rst_x", x, HC);
    chk("mid_rst_y", y, VC);
    chk("mid_rst_moving", moving, 0);
    chk("mid_rst_state", state_dbg, M_WAIT);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();

`ifdef SCORE_EN
    // saturation
    direction = 4'd0;
    move_speed = 13'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < 8; g++) begin
      ticks(3);
      goal_p2 = 1'b1;
      step();
      goal_p2 = 1'b0;
      step();
    end
    chk("sat_pre_score", score_p1, 8);
    ticks(3);
    goal_p2 = 1'b1;
    step();
    goal_p2 = 1'b0;
    chk("sat_score", score_p1, 9);
    chk("sat_state", state_dbg, M_WAIT);
    for (int g = 0; g < 2; g++) begin
      goal_p2 = 1'b1;
      step();
      goal_p2 = 1'b0;
      step();
    end
    chk("sat_ignored_score", score_p1, 9);
    chk("sat_ignored_state", state_dbg, M_WAIT);
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
`endif

    // randomized play
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 15) == 0);
      direction = 4'($urandom_range(0, 15));
      move_speed = 13'($urandom_range(0, 300));
      size = 13'($urandom_range(4, 64));
      if ($urandom_range(0, 11) == 0) goal_p1 = ~goal_p1;
      if ($urandom_range(0, 11) == 0) goal_p2 = ~goal_p2;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 SHALL have parameter H_MAX, default 13'd2560, horizontal field extent in position units.
REQ-002 SHALL have parameter V_MAX, default 13'd1920, vertical field extent.
REQ-003 SHALL have parameter SERVE_TICKS, default 8'd60, frame ticks of pause before each serve.
REQ-004 SHALL have port clk, input, 1, single clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port tick, input, 1, one-cycle frame strobe; position advances only on tick.
REQ-007 SHALL have port start, input, 1, level; releases ball from WAIT.
REQ-008 SHALL have port direction, input, 4, heading code from the direction stage: 0 up, 4 right, 8 down, 12 left, 22.5-degree steps clockwise.
REQ-009 SHALL have port move_speed, input, 13, step magnitude per tick along the heading.
REQ-010 SHALL have port size, input, 13, ball half-size.
REQ-011 SHALL have port goal_p1 and goal_p2, input, 1 each, level flags: ball lost on player-1 or player-2 side.
REQ-012 SHALL have port x and y, output, 13 each, registered ball centre.
REQ-013 SHALL have port serve, output, 1, one-cycle pulse on SERVE->MOVE; drives the direction stage's re-serve input.
REQ-014 SHALL have port moving, output, 1, high only in MOVE.

Function
REQ-015 SHALL implement states WAIT, SERVE, MOVE; WAIT->SERVE when start=1; SERVE->MOVE when serve counter reaches SERVE_TICKS; MOVE->SERVE on accepted goal.
REQ-016 SHALL count the serve counter only on tick in SERVE, clear it on SERVE entry, and assert serve in the cycle of the SERVE->MOVE transition.
REQ-017 SHALL hold x=H_MAX/2, y=V_MAX/2 in WAIT and SERVE.
REQ-018 SHALL, in MOVE on tick, add dx=(move_speed*kx)>>4 and dy=(move_speed*ky)>>4 with signs from the heading; |k| table by angle offset from axis: 0->16, 1->15, 2->11, 3->6, 4->0 (sin component kx, cos component ky; y decreases for up).
REQ-019 SHALL compute products at 18 bits unsigned and next positions at 14 bits signed before clamping.
REQ-020 SHALL clamp y to [size, V_MAX-size] and x to [size, H_MAX-size], landing exactly on the limit so the direction stage's equality wall test fires.
REQ-021 SHALL accept a goal only on the rising edge of goal_p1 or goal_p2 (registered previous value); held levels SHALL NOT retrigger.
REQ-022 SHALL give an accepted goal priority over tick in the same cycle: position recentres and the tick is discarded.
REQ-023 SHALL, on simultaneous goal_p1 and goal_p2 rising edges, treat the event as goal_p1 only.
REQ-024 SHALL ignore start outside WAIT, and ignore goals outside MOVE (no edge memory carried over).
REQ-025 SHALL update x, y, moving and serve with one-cycle latency from their causing event.

Reset
REQ-026 SHALL, on rst=0 at any time including mid-MOVE, force state WAIT, x=H_MAX/2, y=V_MAX/2, serve=0, moving=0, serve counter=0, goal edge registers=0.
REQ-027 SHALL leave reset synchronously to clk; first state change occurs no earlier than the second clk edge after rst rises.

Configuration
REQ-028 SHALL, with SCORE_EN defined, add outputs score_p1 and score_p2 (4 bits each): an accepted goal_p1 increments score_p2, goal_p2 increments score_p1; each saturates at 9; both reset to 0; score 9 reached forces WAIT instead of SERVE.
REQ-029 SHALL, without SCORE_EN, omit score ports and logic entirely; goals always go to SERVE.

Verification
REQ-030 SHALL test reset centring: rst=0 mid-MOVE at x=300 -> next edge x=1280, y=960, moving=0, state WAIT.
REQ-031 SHALL test the serve delay: start=1, SERVE_TICKS=3, three ticks -> serve pulse exactly one cycle, moving=1 next cycle.
REQ-032 SHALL test the diagonal step: direction=2, move_speed=16, one tick from (1280,960) -> (1291,949).
REQ-033 SHALL test the wall clamp: direction=7, size=8, y=1905, move_speed=16, tick -> y=1912 exactly.
REQ-034 SHALL test goal edge plus priority: goal_p1 rises with tick in MOVE -> recentre, SERVE; goal_p1 held 20 cycles -> no second event; with SCORE_EN, score_p2=1.
REQ-035 SHALL test saturation (SCORE_EN): score_p1=8 plus goal_p2 edge -> score_p1=9 and state WAIT; further goal_p2 edges ignored.
